mobius_loader: RTL and testbench

MOBIUS_LOADER -- requirements
Module: mobius_loader

---
 rtl/mobius_loader.sv | 119 +++++++++++
 tb/tb_mobius_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mobius_loader.sv
// -----------------------------------------------------------------------------
// mobius_loader
//
// Purpose:
//   Assembles an N-bit truth table from N/W consecutive W-bit words and
//   presents it, held stable, to a downstream Mobius transform. Two states:
//   FILL accepts words, FULL presents the finished vector until the consumer
//   takes it.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst         synchronous active-high reset (clears state, counter, vector)
//   flush       (only with MOBIUS_LOADER_FLUSH_EN) restart the current fill
//   in_data     one truth-table word, in_data[i] -> out_vector[k*W+i]
//   in_valid    in_data is valid
//   in_ready    loader accepts a word this cycle (high exactly in FILL)
//   out_vector  assembled truth table, index 0 first
//   out_valid   out_vector complete and stable (high exactly in FULL)
//   out_ready   consumer has taken out_vector
//
// Configuration:
//   MOBIUS_LOADER_FLUSH_EN  adds the flush input. Undefined by default.
// -----------------------------------------------------------------------------
module mobius_loader #(
    parameter int N = 256,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
`ifdef MOBIUS_LOADER_FLUSH_EN
    input  logic         flush,
`endif
    input  logic [0:W-1] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:N-1] out_vector,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int WORDS = N / W;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [0:N-1]       vec_q,   vec_d;
    logic               flush_w;

`ifdef MOBIUS_LOADER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;

        case (state_q)
            S_FILL: begin
                // Flush restarts the fill and wins over a same-edge word;
                // bits already written simply hold until overwritten.
                if (flush_w) begin
                    cnt_d = '0;
                end else if (in_valid) begin
                    // Constant-index slot decode keeps every slice static.
                    for (int k = 0; k < WORDS; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            vec_d[k*W +: W] = in_data;
                        end
                    end
                    if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = S_FULL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FULL: begin
                // in_valid and flush are ignored here; the vector is frozen.
                if (out_ready) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of its peers. The vector is reset as well
    // because a cleared table after reset is part of the observable contract.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
        end
    end

    // Handshakes decode registered state only, so neither has an input path.
    assign in_ready   = (state_q == S_FILL);
    assign out_valid  = (state_q == S_FULL);
    assign out_vector = vec_q;

endmodule

// File: tb/tb_mobius_loader.sv
// -----------------------------------------------------------------------------
// tb_mobius_loader
//
// Self-checking bench for mobius_loader at N=16, W=4. A driver issues
// directed and random stimulus and keeps a word-level reference model (a
// queue of accepted words per fill); completed fills push their expected
// vector into a scoreboard. An independent monitor pops that scoreboard
// whenever out_valid rises, checks the vector, its stability while held, and
// the Mobius transform of the DUT output against a direct subset-sum model.
// -----------------------------------------------------------------------------
module tb_mobius_loader;

    localparam int N     = 16;
    localparam int W     = 4;
    localparam int WORDS = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic [0:W-1] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] out_vector;
    logic         out_valid;
    logic         out_ready;
`ifdef MOBIUS_LOADER_FLUSH_EN
    logic         flush;
`endif

    always #5 clk = ~clk;

    mobius_loader #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef MOBIUS_LOADER_FLUSH_EN
        .flush      (flush),
`endif
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_vector (out_vector),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected vectors, words of the fill in progress,
    // and whether the model is currently presenting a vector.
    logic [0:N-1] sb_q[$];
    logic [0:W-1] part_q[$];
    bit           m_full;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [0:N-1] pack_words(input logic [0:W-1] w[$]);
        logic [0:N-1] v = '0;
        for (int k = 0; k < w.size(); k++)
            for (int i = 0; i < W; i++)
                v[k*W + i] = w[k][i];
        return v;
    endfunction

    // Mobius transform by definition: r[u] = XOR of f[v] over all v subset of u.
    function automatic logic [0:N-1] mobius_def(input logic [0:N-1] f);
        logic [0:N-1] r = '0;
        for (int u = 0; u < N; u++) begin
            logic acc = 1'b0;
            for (int v = 0; v < N; v++)
                if ((v & ~u) == 0) acc ^= f[v];
            r[u] = acc;
        end
        return r;
    endfunction

    // Same transform via the in-place butterfly, applied to the DUT output.
    function automatic logic [0:N-1] mobius_fast(input logic [0:N-1] f);
        logic [0:N-1] r = f;
        for (int s = 1; s < N; s = s << 1)
            for (int u = 0; u < N; u++)
                if ((u & s) != 0) r[u] = r[u] ^ r[u ^ s];
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check handshakes against the
    // model, advance the model for the coming rising edge, return at the next
    // falling edge.
    task automatic cycle(input bit r, input bit v, input logic [0:W-1] d,
                         input bit o, input bit f);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = o;
`ifdef MOBIUS_LOADER_FLUSH_EN
        flush     = f;
`endif
        check("in_ready", 64'(in_ready), 64'(!m_full));
        check("out_valid", 64'(out_valid), 64'(m_full));
        if (r) begin
            m_full = 1'b0;
            part_q.delete();
        end else if (!m_full) begin
            if (f) begin
                part_q.delete();
            end else if (v) begin
                part_q.push_back(d);
                if (part_q.size() == WORDS) begin
                    sb_q.push_back(pack_words(part_q));
                    part_q.delete();
                    m_full = 1'b1;
                end
            end
        end else if (o) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic word(input logic [0:W-1] d);
        cycle(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit o);
        cycle(1'b0, 1'b0, 4'h0, o, 1'b0);
    endtask

    // Monitor: scoreboard pop on each rising out_valid, stability while held.
    initial begin : monitor
        bit           prev = 1'b0;
        logic [0:N-1] held = '0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && !prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_vector actual=%0h expected=none at %0t",
                             out_vector, $time);
                end else begin
                    held = sb_q.pop_front();
                    check("vector", 64'(out_vector), 64'(held));
                    check("mobius", 64'(mobius_fast(out_vector)), 64'(mobius_def(held)));
                end
            end else if (out_valid === 1'b1) begin
                check("vector_stable", 64'(out_vector), 64'(held));
            end
            prev = (out_valid === 1'b1);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [0:W-1] rd;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef MOBIUS_LOADER_FLUSH_EN
        flush = 1'b0;
`endif
        m_full = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_vector", 64'(out_vector), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        check("reset_out_valid", 64'(out_valid), 64'h0);

        // Consecutive words 1,2,3,4 -> 0001_0010_0011_0100, valid next cycle.
        word(4'h1); word(4'h2); word(4'h3); word(4'h4);
        idle(1'b1);

        // in_valid toggling with junk data on the idle cycles.
        cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0); cycle(1'b0, 1'b0, 4'h5, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'h0, 1'b0, 1'b0); cycle(1'b0, 1'b0, 4'h9, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b0); cycle(1'b0, 1'b0, 4'h6, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

        // Held FULL for 10 cycles while in_valid=1 with 0xA, then released.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'hA, 1'b1, 1'b0);
        word(4'h7); word(4'h8); word(4'h9); word(4'hB);
        idle(1'b1);

        // Reset after two words discards the partial fill.
        word(4'hC); word(4'hD);
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        check("midfill_reset_vector", 64'(out_vector), 64'h0);
        word(4'h3); word(4'h5); word(4'h6); word(4'hE);
        idle(1'b1);

        // Back-to-back vectors with out_ready held high: N/W+1 cycles each.
        for (int n = 0; n < 6; n++)
            for (int k = 0; k <= WORDS; k++) begin
                rd = 4'($urandom_range(0, 15));
                cycle(1'b0, 1'b1, rd, 1'b1, 1'b0);
            end
        idle(1'b1);

`ifdef MOBIUS_LOADER_FLUSH_EN
        // Flush after three words, coincident with a valid word.
        word(4'h1); word(4'h2); word(4'h3);
        cycle(1'b0, 1'b1, 4'hF, 1'b0, 1'b1);
        word(4'h8); word(4'h4); word(4'h2); word(4'h1);
        idle(1'b1);
`endif

        // Random traffic including occasional reset and (if present) flush.
        for (int i = 0; i < 300; i++) begin
            bit f;
            rd = 4'($urandom_range(0, 15));
`ifdef MOBIUS_LOADER_FLUSH_EN
            f = ($urandom_range(0, 9) == 0);
`else
            f = 1'b0;
`endif
            cycle(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)), rd,
                  ($urandom_range(0, 3) != 0), f);
        end
        idle(1'b1);
        idle(1'b1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
